// File: rtl/spi_responder_if.sv
// spi_responder_if: SPI pins plus CPU-side strobe/data signals of the SPI responder
interface spi_responder_if;
   logic        sclk;
   logic        mosi;
   logic        ss;
   logic        miso;
   logic        miso_en;
   logic        wide;
   logic [31:0] data_tx;
   logic        start_tx;
   logic        txrdy;
   logic [31:0] data_rx;
   logic        rdy;
   logic        done;
   logic        ovr;
   modport slave (
      input  sclk, mosi, ss, wide, data_tx, start_tx, done,
      output miso, miso_en, txrdy, data_rx, rdy, ovr
   );
   modport master (
      output sclk, mosi, ss, wide, data_tx, start_tx, done,
      input  miso, miso_en, txrdy, data_rx, rdy, ovr
   );
endinterface

// File: rtl/spi_responder.sv
// spi_responder: mode-0 MSB-first SPI slave with 8/32-bit frames and a strobe-style CPU side
module spi_responder #(
   parameter int SYNC = 2
) (
   input logic           clk,
   input logic           rst,
   spi_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t      state, state_nx;
   logic [SYNC-1:0] sclk_s, mosi_s, ss_s;
   logic        sclk_d, ss_d;
   logic        sclk_v, mosi_v, ss_v;
   logic        rise, fall, ss_fall, frame_end, reload;
   logic [31:0] txsh, tx_buf;
   logic [30:0] rxsh;
   logic [5:0]  cnt;
   logic        mode, pend;
   assign sclk_v    = sclk_s[SYNC-1];
   assign mosi_v    = mosi_s[SYNC-1];
   assign ss_v      = ss_s[SYNC-1];
   assign ss_fall   = ss_d & ~ss_v;
   assign rise      = (state == SHIFT) & ~ss_v & sclk_v & ~sclk_d;
   assign fall      = (state == SHIFT) & ~ss_v & ~sclk_v & sclk_d;
   assign frame_end = rise & (cnt + 6'd1 == (mode ? 6'd32 : 6'd8));
   // a pending reload (set at frame end) is served on the next SCLK fall
   assign reload    = (state == LOAD) | (fall & pend);
   // synchronise the master pins and keep one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_s <= '0;
         mosi_s <= '0;
         ss_s   <= '1;
         sclk_d <= 1'b0;
         ss_d   <= 1'b1;
      end else begin
         sclk_s <= {sclk_s[SYNC-2:0], bus.sclk};
         mosi_s <= {mosi_s[SYNC-2:0], bus.mosi};
         ss_s   <= {ss_s[SYNC-2:0], bus.ss};
         sclk_d <= sclk_v;
         ss_d   <= ss_v;
      end
   end
   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end
   // next state and pad drive; MISO idles high whenever the pad is not driven
   always_comb begin
      state_nx    = state;
      bus.miso_en = 1'b0;
      bus.miso    = 1'b1;
      case (state)
         IDLE:  state_nx = ss_fall ? LOAD : IDLE;
         LOAD: begin
            state_nx    = SHIFT;
            bus.miso_en = 1'b1;
         end
         SHIFT: begin
            state_nx    = ss_v ? IDLE : SHIFT;
            bus.miso_en = 1'b1;
            bus.miso    = mode ? txsh[31] : txsh[7];
         end
         default: state_nx = IDLE;
      endcase
   end
   // shift registers, tx buffer, bit counter and CPU status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txsh        <= '1;
         rxsh        <= '0;
         tx_buf      <= '0;
         cnt         <= '0;
         mode        <= 1'b0;
         pend        <= 1'b0;
         bus.txrdy   <= 1'b1;
         bus.data_rx <= '0;
         bus.rdy     <= 1'b0;
         bus.ovr     <= 1'b0;
      end else begin
         if (state == LOAD) mode <= bus.wide;
         if (reload) txsh <= bus.txrdy ? '1 : tx_buf;
         else if (fall) txsh <= {txsh[30:0], 1'b1};
         if (bus.start_tx) tx_buf <= bus.data_tx;
         bus.txrdy <= bus.start_tx ? 1'b0 : (reload | bus.txrdy);
         if (rise) begin
            rxsh <= {rxsh[29:0], mosi_v};
            cnt  <= frame_end ? 6'd0 : cnt + 6'd1;
         end else if (state != SHIFT || ss_v) cnt <= '0;
         pend <= frame_end | (pend & ~reload & (state == SHIFT));
         if (frame_end) bus.data_rx <= mode ? {rxsh, mosi_v} : {24'h0, rxsh[6:0], mosi_v};
         bus.rdy <= frame_end | (bus.rdy & ~bus.done);
         bus.ovr <= frame_end ? (bus.ovr | (bus.rdy & ~bus.done)) : (bus.ovr & ~bus.done);
      end
   end
endmodule
